// File: rtl/store_buffer_pkg.sv
// Shared encodings and entry record for the store buffer and its FIFO.
package store_buffer_pkg;
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_WORD = 2'b01;
  localparam logic [1:0] ST_HALF = 2'b10;
  localparam logic [1:0] ST_BYTE = 2'b11;

  typedef struct packed {
    logic [1:0]  st_type;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } sb_entry_t;

  localparam int ENTRY_W        = $bits(sb_entry_t);
  localparam int ENTRY_ADDR_LSB = 64;
endpackage

// File: rtl/store_buffer_fifo.sv
// Generic DEPTH-entry circular FIFO of store records, with a per-slot
// valid/word-address view for hazard comparison.
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [ENTRY_W-1:0]        push_entry,
  input  logic                      pop,
  output logic [ENTRY_W-1:0]        head_entry,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DEPTH-1:0]          entry_valid,
  output logic [DEPTH*30-1:0]       entry_word
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   offset;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push) begin
      mem_d[tail_q] = push_entry;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    entry_valid = '0;
    entry_word  = '0;
    offset      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset                 = PTR_W'(i) - head_q;
      entry_valid[i]         = ({1'b0, offset} < count_q);
      entry_word[i*30 +: 30] = mem_q[i][ENTRY_ADDR_LSB+2 +: 30];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;
endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: queues MEM-stage stores, drains one per cycle into
// the data memory when no load owns the port, and flags load/store overlap.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   StValid,
  input  logic [1:0]             StType,
  input  logic [31:0]            StAddr,
  input  logic [31:0]            StData,
  input  logic [31:0]            StPC,
  output logic                   StReady,
  input  logic                   LdValid,
  input  logic [31:0]            LdAddr,
  output logic                   LdHazard,
  output logic [1:0]             MemWE,
  output logic [31:0]            MemA,
  output logic [31:0]            MemWD,
  output logic [31:0]            MemPC,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Empty
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0] head_raw;
  sb_entry_t          head;
  sb_entry_t          push_entry;
  logic [CNT_W-1:0]   count;
  logic [DEPTH-1:0]   entry_valid;
  logic [DEPTH*30-1:0] entry_word;
  logic               st_accept;
  logic               drain;
  logic               queued_hit;
  logic               unused_ld_lanes;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (CLK),
    .rst         (RESET),
    .push        (st_accept),
    .push_entry  (push_entry),
    .pop         (drain),
    .head_entry  (head_raw),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_word  (entry_word)
  );

  assign head = head_raw;

  // Readiness looks only at registered occupancy; a same-cycle pop never
  // frees a slot for a push.
  always_comb begin
    StReady    = (count < CNT_W'(DEPTH));
    Empty      = (count == '0);
    Count      = count;
    st_accept  = StValid && (StType != ST_NONE) && StReady;
    push_entry = '{st_type: StType, addr: StAddr, data: StData, pc: StPC};
    drain      = !Empty && !LdValid && !RESET;
  end

  always_comb begin
    MemWE = drain ? head.st_type : ST_NONE;
    MemA  = Empty ? '0 : head.addr;
    MemWD = Empty ? '0 : head.data;
    MemPC = Empty ? '0 : head.pc;
  end

  // Word-granular overlap against queued entries and the store entering now.
  always_comb begin
    queued_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_word[i*30 +: 30] == LdAddr[31:2])) queued_hit = 1'b1;
    end
    LdHazard = LdValid && (queued_hit || (st_accept && (StAddr[31:2] == LdAddr[31:2])));
  end

  assign unused_ld_lanes = ^LdAddr[1:0];
endmodule

// File: tb/tb_store_buffer.sv
// Directed vector bench for store_buffer: table of per-cycle stimulus with
// hand-computed outputs, plus a full-buffer-under-loads sequence.
module tb_store_buffer;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        StValid;
  logic [1:0]  StType;
  logic [31:0] StAddr, StData, StPC;
  logic        StReady;
  logic        LdValid;
  logic [31:0] LdAddr;
  logic        LdHazard;
  logic [1:0]  MemWE;
  logic [31:0] MemA, MemWD, MemPC;
  logic [2:0]  Count;
  logic        Empty;

  store_buffer #(.DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .StValid(StValid), .StType(StType),
    .StAddr(StAddr), .StData(StData), .StPC(StPC), .StReady(StReady),
    .LdValid(LdValid), .LdAddr(LdAddr), .LdHazard(LdHazard),
    .MemWE(MemWE), .MemA(MemA), .MemWD(MemWD), .MemPC(MemPC),
    .Count(Count), .Empty(Empty)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        sv;
    logic [1:0]  st;
    logic [31:0] sa, sd, sp;
    logic        lv;
    logic [31:0] la;
  } stim_t;

  typedef struct {
    logic [1:0]  we;
    logic [31:0] ma, mwd, mpc;
    logic [2:0]  cnt;
    logic        hz;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t vecs[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic stim_t idle(input logic lv, input logic [31:0] la);
    stim_t s;
    s = '{rst: 1'b0, sv: 1'b0, st: 2'b00, sa: 32'h0, sd: 32'h0, sp: 32'h0, lv: lv, la: la};
    return s;
  endfunction

  function automatic stim_t st(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] pc, input logic lv, input logic [31:0] la);
    stim_t s;
    s = '{rst: 1'b0, sv: 1'b1, st: t, sa: a, sd: d, sp: pc, lv: lv, la: la};
    return s;
  endfunction

  function automatic exp_t ex(input logic [1:0] we, input logic [31:0] ma, input logic [31:0] mwd,
                              input logic [31:0] mpc, input logic [2:0] cnt, input logic hz);
    exp_t e;
    e = '{we: we, ma: ma, mwd: mwd, mpc: mpc, cnt: cnt, hz: hz};
    return e;
  endfunction

  task automatic add(input stim_t s, input exp_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input stim_t s);
    RESET   = s.rst;
    StValid = s.sv;
    StType  = s.st;
    StAddr  = s.sa;
    StData  = s.sd;
    StPC    = s.sp;
    LdValid = s.lv;
    LdAddr  = s.la;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step_edge();
    @(posedge CLK);
    #1;
  endtask

  exp_t z;

  initial begin
    z = ex(2'b00, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);

    // Reset state, then a single word store drains on the following cycle.
    begin
      stim_t r;
      r = idle(1'b0, 32'h0);
      r.rst = 1'b1;
      add(r, z);
    end
    add(st(2'b01, 32'h10, 32'hDEADBEEF, 32'h100, 1'b0, 32'h0), z);
    add(idle(1'b0, 32'h0), ex(2'b01, 32'h10, 32'hDEADBEEF, 32'h100, 3'd1, 1'b0));
    add(idle(1'b0, 32'h0), z);

    // Fill to full behind a load; the fifth store (address equals load) is refused.
    add(st(2'b01, 32'h200, 32'h1, 32'h500, 1'b1, 32'h800), z);
    add(st(2'b01, 32'h204, 32'h2, 32'h504, 1'b1, 32'h800), ex(2'b00, 32'h200, 32'h1, 32'h500, 3'd1, 1'b0));
    add(st(2'b01, 32'h208, 32'h3, 32'h508, 1'b1, 32'h800), ex(2'b00, 32'h200, 32'h1, 32'h500, 3'd2, 1'b0));
    add(st(2'b01, 32'h20C, 32'h4, 32'h50C, 1'b1, 32'h800), ex(2'b00, 32'h200, 32'h1, 32'h500, 3'd3, 1'b0));
    add(st(2'b01, 32'h210, 32'h5, 32'h510, 1'b1, 32'h210), ex(2'b00, 32'h200, 32'h1, 32'h500, 3'd4, 1'b0));
    add(idle(1'b1, 32'h800), ex(2'b00, 32'h200, 32'h1, 32'h500, 3'd4, 1'b0));
    add(idle(1'b0, 32'h0), ex(2'b01, 32'h200, 32'h1, 32'h500, 3'd4, 1'b0));
    add(idle(1'b0, 32'h0), ex(2'b01, 32'h204, 32'h2, 32'h504, 3'd3, 1'b0));
    add(idle(1'b0, 32'h0), ex(2'b01, 32'h208, 32'h3, 32'h508, 3'd2, 1'b0));
    add(idle(1'b0, 32'h0), ex(2'b01, 32'h20C, 32'h4, 32'h50C, 3'd1, 1'b0));
    add(idle(1'b0, 32'h0), z);

    // Byte then half, drain held off by loads for two cycles, then in order.
    add(st(2'b11, 32'h21, 32'hAB, 32'h300, 1'b0, 32'h0), z);
    add(st(2'b10, 32'h34, 32'h1234, 32'h304, 1'b1, 32'h900), ex(2'b00, 32'h21, 32'hAB, 32'h300, 3'd1, 1'b0));
    add(idle(1'b1, 32'h900), ex(2'b00, 32'h21, 32'hAB, 32'h300, 3'd2, 1'b0));
    add(idle(1'b0, 32'h0), ex(2'b11, 32'h21, 32'hAB, 32'h300, 3'd2, 1'b0));
    add(idle(1'b0, 32'h0), ex(2'b10, 32'h34, 32'h1234, 32'h304, 3'd1, 1'b0));
    add(idle(1'b0, 32'h0), z);

    // Hazard: incoming match, queued match, neighbour word, after drain.
    add(st(2'b01, 32'h104, 32'h55, 32'h400, 1'b1, 32'h107), ex(2'b00, 32'h0, 32'h0, 32'h0, 3'd0, 1'b1));
    add(idle(1'b1, 32'h107), ex(2'b00, 32'h104, 32'h55, 32'h400, 3'd1, 1'b1));
    add(idle(1'b1, 32'h108), ex(2'b00, 32'h104, 32'h55, 32'h400, 3'd1, 1'b0));
    add(idle(1'b0, 32'h0), ex(2'b01, 32'h104, 32'h55, 32'h400, 3'd1, 1'b0));
    add(idle(1'b1, 32'h107), z);

    // Ten back-to-back stores: steady-state Count 1, pointers wrap.
    for (int k = 0; k < 10; k++) begin
      if (k == 0) add(st(2'b01, 32'h1000, 32'hA0, 32'h600, 1'b0, 32'h0), z);
      else add(st(2'b01, 32'h1000 + 4*k, 32'hA0 + k, 32'h600 + 4*k, 1'b0, 32'h0),
               ex(2'b01, 32'h1000 + 4*(k-1), 32'hA0 + (k-1), 32'h600 + 4*(k-1), 3'd1, 1'b0));
    end
    add(idle(1'b0, 32'h0), ex(2'b01, 32'h1024, 32'hA9, 32'h624, 3'd1, 1'b0));
    add(idle(1'b0, 32'h0), z);

    // Reset with three entries queued and a store arriving in the reset cycle.
    add(st(2'b01, 32'h2000, 32'hC0, 32'h700, 1'b1, 32'h900), z);
    add(st(2'b01, 32'h2004, 32'hC1, 32'h704, 1'b1, 32'h900), ex(2'b00, 32'h2000, 32'hC0, 32'h700, 3'd1, 1'b0));
    add(st(2'b01, 32'h2008, 32'hC2, 32'h708, 1'b1, 32'h900), ex(2'b00, 32'h2000, 32'hC0, 32'h700, 3'd2, 1'b0));
    begin
      stim_t r;
      r = st(2'b01, 32'h3000, 32'hC3, 32'h70C, 1'b0, 32'h0);
      r.rst = 1'b1;
      add(r, ex(2'b00, 32'h2000, 32'hC0, 32'h700, 3'd3, 1'b0));
    end
    add(idle(1'b0, 32'h0), z);
    add(idle(1'b0, 32'h0), z);

    // Bring the design out of an unknown power-up state.
    begin
      stim_t r;
      r = idle(1'b0, 32'h0);
      r.rst = 1'b1;
      drive(r);
    end
    step_edge();
    step_edge();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].s);
      #1;
      vectors++;
      chk("MemWE",    i, 32'(MemWE),    32'(vecs[i].e.we));
      chk("MemA",     i, MemA,          vecs[i].e.ma);
      chk("MemWD",    i, MemWD,         vecs[i].e.mwd);
      chk("MemPC",    i, MemPC,         vecs[i].e.mpc);
      chk("Count",    i, 32'(Count),    32'(vecs[i].e.cnt));
      chk("Empty",    i, 32'(Empty),    32'(vecs[i].e.cnt == 3'd0));
      chk("StReady",  i, 32'(StReady),  32'(vecs[i].e.cnt != 3'd4));
      chk("LdHazard", i, 32'(LdHazard), 32'(vecs[i].e.hz));
      step_edge();
    end

    // Full buffer under continuous loads: nothing drains, then strict order.
    for (int k = 0; k < 4; k++) begin
      drive(st(2'b01, 32'h4000 + 16*k, 32'hE0 + k, 32'h800 + 4*k, 1'b1, 32'hF00));
      step_edge();
    end
    for (int c = 0; c < 5; c++) begin
      drive(st(2'b01, 32'h5000, 32'hEE, 32'h8F0, 1'b1, 32'hF00));
      #1;
      vectors++;
      chk("full_hold_we",    c, 32'(MemWE),   32'h0);
      chk("full_hold_ready", c, 32'(StReady), 32'h0);
      chk("full_hold_count", c, 32'(Count),   32'h4);
      step_edge();
    end
    begin
      int drained;
      int cycles;
      drained = 0;
      cycles  = 0;
      drive(idle(1'b0, 32'h0));
      #1;
      while (!Empty && cycles < 10) begin
        if (MemWE != 2'b00) begin
          vectors++;
          chk("drain_addr", drained, MemA,  32'h4000 + 16*drained);
          chk("drain_data", drained, MemWD, 32'hE0 + drained);
          drained++;
        end
        step_edge();
        cycles++;
      end
      vectors++;
      chk("drain_done",  cycles,  32'(Empty), 32'h1);
      chk("drain_total", drained, drained,    4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
